cpu_debug_stepper: RTL

// - On-FPGA driver for the cpu_dmem_wrapper debug port; replaces the bench-driven stepping with hardware.
// - Debounces a step button (or free-runs), issues one-cycle pc_advance pulses, waits for settle,

---
 rtl/cpu_debug_stepper.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cpu_debug_stepper.sv
// Hardware step controller for the CPU debug port: debounced button or periodic run requests
// issue a single pc_advance pulse, then the register file is swept into a snapshot buffer.
`timescale 1ns/1ps
module cpu_debug_stepper #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 3,
  parameter int NUM_REGS        = 16,
  parameter int DATA_W          = 16,
  parameter int RUN_PERIOD      = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_btn,
  input  logic              run_en,
  input  logic              halt,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] reg_out,
  output logic              pc_advance,
  output logic [3:0]        reg_index,
  input  logic [3:0]        snap_sel,
  output logic [DATA_W-1:0] snap_data,
  output logic [DATA_W-1:0] snap_pc,
  output logic              snap_valid,
  output logic              busy,
  output logic [15:0]       step_count
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W  = $clog2(RUN_PERIOD + 1);
  localparam int CNT_W = $clog2(NUM_REGS + SETTLE_CYCLES + 2);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PULSE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic            btn_s1, btn_s2, deb_level, btn_req;
  logic [DB_W-1:0] deb_cnt;
  logic [RP_W-1:0] run_cnt;
  logic            run_wrap;
  logic            start;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] snapshot [NUM_REGS];

  // Level only flips after DEBOUNCE_CYCLES consecutive samples disagreeing with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      btn_req   <= 1'b0;
    end else begin
      btn_s1  <= step_btn;
      btn_s2  <= btn_s1;
      btn_req <= 1'b0;
      if (btn_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_level <= btn_s2;
        deb_cnt   <= '0;
        btn_req   <= btn_s2;
      end else begin
        deb_cnt <= deb_cnt + DB_W'(1);
      end
    end
  end

  assign run_wrap = run_en && !halt && (run_cnt == RP_W'(RUN_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (!run_en) begin
      run_cnt <= '0;
    end else if (!halt) begin
      run_cnt <= run_wrap ? '0 : run_cnt + RP_W'(1);
    end
  end

  assign start = (state == S_IDLE) && !halt && (btn_req || run_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      step_count <= '0;
      snap_pc    <= '0;
      snap_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) snapshot[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            state      <= S_PULSE;
            snap_valid <= 1'b0;
          end
        end
        S_PULSE: begin
          step_count <= step_count + 16'd1;
          cnt        <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_SCAN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SCAN: begin
          if (cnt != '0) snapshot[IDX_W'(cnt - CNT_W'(1))] <= reg_out;
          // PC and valid are registered on entry to DONE so they are visible during DONE
          if (cnt == CNT_W'(NUM_REGS)) begin
            snap_pc    <= pc_in;
            snap_valid <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_index = '0;
    if (state == S_SCAN) begin
      if (cnt < CNT_W'(NUM_REGS)) reg_index = 4'(cnt);
      else                        reg_index = 4'(NUM_REGS - 1);
    end
  end

  always_comb begin
    snap_data = '0;
    if (int'(snap_sel) < NUM_REGS) snap_data = snapshot[IDX_W'(snap_sel)];
  end

  assign pc_advance = (state == S_PULSE);
  assign busy       = (state != S_IDLE);

endmodule
